// File: rtl/regs_port_ctrl_if.sv
// Register-port controller bus bundle.
// Carries the core datapath port (read addresses, retire write, stall, read data),
// the host/debug request port (level request, registered ack, captured read data)
// and the register file port (write enable/data, two addresses, two read data).
// slave  : the controller side.
// master : the environment side (core, host and register file).
interface regs_port_ctrl_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 3
);
    // Core side
    logic [AW-1:0] core_ra1;
    logic [AW-1:0] core_ra2;
    logic          core_we;
    logic [N-1:0]  core_wd;
    logic          core_stall;
    logic [N-1:0]  core_rd1;
    logic [N-1:0]  core_rd2;
    // Host side
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [N-1:0]  host_wdata;
    logic          host_ack;
    logic [N-1:0]  host_rdata;
    // Register file side
    logic          rf_write;
    logic [N-1:0]  rf_wdata;
    logic [AW-1:0] rf_raddr1;
    logic [AW-1:0] rf_raddr2;
    logic [N-1:0]  rf_rdata1;
    logic [N-1:0]  rf_rdata2;

    modport slave (
        input  core_ra1, core_ra2, core_we, core_wd,
        output core_stall, core_rd1, core_rd2,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output rf_write, rf_wdata, rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2
    );

    modport master (
        output core_ra1, core_ra2, core_we, core_wd,
        input  core_stall, core_rd1, core_rd2,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  rf_write, rf_wdata, rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2
    );
endinterface

// File: rtl/regs_port_ctrl.sv
// Register file port controller.
// Shares the register file's two read ports and single write port (write address on
// port 1) between the core datapath and a host/debug requester. A host access steals
// one core cycle (core_stall), then HOST_GAP core-owned cycles follow before the next
// host grant. Writes to r0 are always suppressed.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : regs_port_ctrl_if.slave (core, host and register file signals)
//   host_cnt   : completed host accesses, wraps (only with REGS_CTRL_STATS_EN)
//   stall_cnt  : core_stall cycles, wraps (only with REGS_CTRL_STATS_EN)
// Optional feature macro: REGS_CTRL_STATS_EN
module regs_port_ctrl #(
    parameter int unsigned N        = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned HOST_GAP = 4
) (
    input  logic            clk,
    input  logic            reset,
    regs_port_ctrl_if.slave bus
`ifdef REGS_CTRL_STATS_EN
    ,
    output logic [7:0]      host_cnt,
    output logic [7:0]      stall_cnt
`endif
);

    localparam logic [3:0] GapInit = 4'(HOST_GAP);

    typedef enum logic [1:0] {StIdle, StHostAcc, StCooldown} state_e;

    state_e         state_q, state_d;
    logic [3:0]     gap_q, gap_d;
    logic           ack_q, ack_d;
    logic [N-1:0]   rdata_q, rdata_d;

    logic [AW-1:0]  addr1;
    logic [N-1:0]   wdata;
    logic           we;
    logic           stall;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (bus.host_req) begin
                    state_d = StHostAcc;
                end
            end
            StHostAcc: begin
                // Port 1 carries host_addr this cycle, so this is the pre-write value.
                rdata_d = bus.rf_rdata1;
                ack_d   = 1'b1;
                gap_d   = GapInit;
                state_d = StCooldown;
            end
            StCooldown: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Port muxing
    always_comb begin
        addr1 = bus.core_ra1;
        wdata = bus.core_wd;
        we    = bus.core_we;
        stall = 1'b0;
        if (state_q == StHostAcc) begin
            addr1 = bus.host_addr;
            wdata = bus.host_wdata;
            we    = bus.host_we;
            stall = 1'b1;
        end
        if (addr1 == '0) begin
            we = 1'b0;
        end
        if (reset) begin
            we    = 1'b0;
            stall = 1'b0;
        end
    end

    assign bus.rf_raddr1  = addr1;
    assign bus.rf_raddr2  = bus.core_ra2;
    assign bus.rf_wdata   = wdata;
    assign bus.rf_write   = we;
    assign bus.core_stall = stall;
    assign bus.core_rd1   = bus.rf_rdata1;
    assign bus.core_rd2   = bus.rf_rdata2;
    assign bus.host_ack   = ack_q;
    assign bus.host_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            gap_q   <= 4'd0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef REGS_CTRL_STATS_EN
    logic [7:0] host_cnt_q, host_cnt_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        host_cnt_d  = host_cnt_q + {7'd0, (state_q == StHostAcc)};
        stall_cnt_d = stall_cnt_q + {7'd0, stall};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            host_cnt_q  <= 8'd0;
            stall_cnt_q <= 8'd0;
        end else begin
            host_cnt_q  <= host_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign host_cnt  = host_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_regs_port_ctrl.sv
module tb_regs_port_ctrl;
    localparam int unsigned N   = 8;
    localparam int unsigned AW  = 3;
    localparam int unsigned GAP = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regs_port_ctrl_if #(.N(N), .AW(AW)) bus ();

`ifdef REGS_CTRL_STATS_EN
    logic [7:0] host_cnt;
    logic [7:0] stall_cnt;
`endif

    regs_port_ctrl #(.N(N), .AW(AW), .HOST_GAP(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus)
`ifdef REGS_CTRL_STATS_EN
        ,
        .host_cnt (host_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    // Register file: combinational read, r0 reads zero, write at the clock edge.
    logic [N-1:0] rf [8] = '{default: '0};
    always_comb begin
        bus.rf_rdata1 = (bus.rf_raddr1 == '0) ? '0 : rf[bus.rf_raddr1];
        bus.rf_rdata2 = (bus.rf_raddr2 == '0) ? '0 : rf[bus.rf_raddr2];
    end
    always @(posedge clk) begin
        if (bus.rf_write) rf[bus.rf_raddr1] <= bus.rf_wdata;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, checks happen at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic idle_inputs();
        bus.core_ra1   = '0;
        bus.core_ra2   = '0;
        bus.core_we    = 1'b0;
        bus.core_wd    = '0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
    endtask

    typedef struct {
        logic         hwe;
        logic [2:0]   haddr;
        logic [7:0]   hwd;
        logic         cwe;
        logic [2:0]   cra;
        logic [7:0]   cwd;
        logic [7:0]   exp_rdata;
        logic         exp_rfw;
        logic [7:0]   exp_after;
    } txn_t;

    txn_t tbl [6];

    // Random-phase reference model state
    logic [7:0] rm [8];
    int         g;
    int         next_ok;
    logic [7:0] exp_rd;
    logic [7:0] cap;
    logic       e_stall, e_ack, e_w, rel;
    int         n_st, n_ack;

    initial begin
        tbl[0] = '{1'b1, 3'd5, 8'hC3, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'hC3};
        tbl[1] = '{1'b0, 3'd3, 8'h00, 1'b1, 3'd3, 8'h77, 8'h5A, 1'b0, 8'h5A};
        tbl[2] = '{1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 3'd3, 8'h11, 1'b1, 3'd3, 8'h22, 8'h5A, 1'b1, 8'h11};
        tbl[4] = '{1'b0, 3'd5, 8'h00, 1'b1, 3'd5, 8'h99, 8'hC3, 1'b0, 8'hC3};
        tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00};

        // Reset: a core write presented during reset must not land.
        reset = 1'b1;
        idle_inputs();
        bus.core_we  = 1'b1;
        bus.core_ra1 = 3'd3;
        bus.core_wd  = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("reset_rf_write", bus.rf_write, 1'b0);
        chk("reset_stall", bus.core_stall, 1'b0);
        chk("reset_ack", bus.host_ack, 1'b0);
        chk("reset_rdata", bus.host_rdata, 8'h00);
`ifdef REGS_CTRL_STATS_EN
        chk("reset_host_cnt", host_cnt, 8'd0);
        chk("reset_stall_cnt", stall_cnt, 8'd0);
`endif

        // Core write 5A to r3, then read it back.
        cyc();
        reset        = 1'b0;
        bus.core_we  = 1'b1;
        bus.core_ra1 = 3'd3;
        bus.core_wd  = 8'h5A;
        settle();
        chk("core_wr_rf_write", bus.rf_write, 1'b1);
        chk("core_wr_stall", bus.core_stall, 1'b0);
        cyc();
        bus.core_we = 1'b0;
        settle();
        chk("core_rd_r3", bus.core_rd1, 8'h5A);
        chk("core_rd_ack", bus.host_ack, 1'b0);

        // Core write to r0 is suppressed.
        cyc();
        bus.core_we  = 1'b1;
        bus.core_ra1 = 3'd0;
        bus.core_wd  = 8'hFF;
        settle();
        chk("core_r0_rf_write", bus.rf_write, 1'b0);
        cyc();
        bus.core_we = 1'b0;
        settle();
        chk("core_r0_read", bus.core_rd1, 8'h00);

        // Table of host transactions.
        for (int i = 0; i < 6; i++) begin
            cyc();
            idle_inputs();
            bus.host_req   = 1'b1;
            bus.host_we    = tbl[i].hwe;
            bus.host_addr  = tbl[i].haddr;
            bus.host_wdata = tbl[i].hwd;
            settle();
            chk($sformatf("txn%0d_decision_stall", i), bus.core_stall, 1'b0);
            cyc();
            bus.core_we  = tbl[i].cwe;
            bus.core_ra1 = tbl[i].cra;
            bus.core_wd  = tbl[i].cwd;
            settle();
            chk($sformatf("txn%0d_grant_stall", i), bus.core_stall, 1'b1);
            chk($sformatf("txn%0d_rf_write", i), bus.rf_write, tbl[i].exp_rfw);
            chk($sformatf("txn%0d_raddr1", i), bus.rf_raddr1, tbl[i].haddr);
            chk($sformatf("txn%0d_early_ack", i), bus.host_ack, 1'b0);
            cyc();
            bus.host_req = 1'b0;
            bus.core_we  = 1'b0;
            settle();
            chk($sformatf("txn%0d_ack", i), bus.host_ack, 1'b1);
            chk($sformatf("txn%0d_rdata", i), bus.host_rdata, tbl[i].exp_rdata);
            chk($sformatf("txn%0d_ack_stall", i), bus.core_stall, 1'b0);
            cyc();
            bus.core_ra1 = tbl[i].haddr;
            settle();
            chk($sformatf("txn%0d_ack_pulse", i), bus.host_ack, 1'b0);
            chk($sformatf("txn%0d_rdata_hold", i), bus.host_rdata, tbl[i].exp_rdata);
            chk($sformatf("txn%0d_reg_after", i), bus.core_rd1, tbl[i].exp_after);
            repeat (GAP) cyc();
        end

        // Reset during HOST_ACC of a host write to r2.
        cyc();
        idle_inputs();
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 3'd2;
        bus.host_wdata = 8'hAA;
        settle();
        cyc();
        reset = 1'b1;
        settle();
        chk("rst_acc_rf_write", bus.rf_write, 1'b0);
        chk("rst_acc_stall", bus.core_stall, 1'b0);
        cyc();
        reset       = 1'b0;
        bus.host_we = 1'b0;
        settle();
        chk("rst_acc_no_ack", bus.host_ack, 1'b0);
        chk("rst_acc_rdata", bus.host_rdata, 8'h00);
        chk("rst_acc_idle_stall", bus.core_stall, 1'b0);
        cyc();
        settle();
        chk("rst_acc_regrant", bus.core_stall, 1'b1);
        cyc();
        bus.host_req  = 1'b0;
        settle();
        chk("rst_acc_reread_ack", bus.host_ack, 1'b1);
        chk("rst_acc_r2_unchanged", bus.host_rdata, 8'h00);
`ifdef REGS_CTRL_STATS_EN
        chk("stats_host_cnt_1", host_cnt, 8'd1);
        chk("stats_stall_cnt_1", stall_cnt, 8'd1);
`endif

        // Reset during COOLDOWN clears the gap counter.
        cyc();
        reset = 1'b1;
        settle();
        cyc();
        reset         = 1'b0;
        bus.host_req  = 1'b1;
        bus.host_addr = 3'd5;
        settle();
        chk("rst_cd_no_ack", bus.host_ack, 1'b0);
        chk("rst_cd_decision_stall", bus.core_stall, 1'b0);
        cyc();
        settle();
        chk("rst_cd_grant", bus.core_stall, 1'b1);
        cyc();
        bus.host_req = 1'b0;
        settle();
        chk("rst_cd_ack", bus.host_ack, 1'b1);
        chk("rst_cd_rdata", bus.host_rdata, 8'hC3);
        repeat (GAP + 1) cyc();

        // host_req held continuously: one stall every GAP+2 cycles.
        idle_inputs();
        bus.host_req  = 1'b1;
        bus.host_addr = 3'd5;
        n_st  = 0;
        n_ack = 0;
        for (int c = 0; c < 6 * (GAP + 2); c++) begin
            if (c > 0) cyc();
            settle();
            chk($sformatf("cont_stall_c%0d", c), bus.core_stall, (c % (GAP + 2)) == 1);
            chk($sformatf("cont_ack_c%0d", c), bus.host_ack, (c % (GAP + 2)) == 2);
            n_st  += int'(bus.core_stall);
            n_ack += int'(bus.host_ack);
        end
        chk("cont_stall_count", n_st, 6);
        chk("cont_ack_count", n_ack, 6);
        cyc();
        bus.host_req = 1'b0;
        repeat (GAP + 1) cyc();

        // Randomized traffic against a cycle-schedule reference model.
        reset = 1'b1;
        settle();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) rm[i] = (i == 0) ? 8'h00 : rf[i];
        g       = -10;
        next_ok = 0;
        exp_rd  = 8'h00;
        cap     = 8'h00;
        rel     = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (c > 0) cyc();
            bus.core_ra1 = 3'($urandom_range(0, 7));
            bus.core_ra2 = 3'($urandom_range(0, 7));
            bus.core_we  = ($urandom_range(0, 2) == 0);
            bus.core_wd  = 8'($urandom);
            if (rel) bus.host_req = 1'b0;
            rel = 1'b0;
            if (!bus.host_req && $urandom_range(0, 3) == 0) begin
                bus.host_req   = 1'b1;
                bus.host_we    = 1'($urandom_range(0, 1));
                bus.host_addr  = 3'($urandom_range(0, 7));
                bus.host_wdata = 8'($urandom);
            end
            settle();
            e_stall = (c == g);
            e_ack   = (c == g + 1);
            if (e_ack) exp_rd = cap;
            if (e_stall) e_w = bus.host_we && (bus.host_addr != 3'd0);
            else         e_w = bus.core_we && (bus.core_ra1 != 3'd0);
            chk("rnd_stall", bus.core_stall, e_stall);
            chk("rnd_ack", bus.host_ack, e_ack);
            chk("rnd_rdata", bus.host_rdata, exp_rd);
            chk("rnd_rf_write", bus.rf_write, e_w);
            chk("rnd_rd2", bus.core_rd2, rm[bus.core_ra2]);
            if (!e_stall) chk("rnd_rd1", bus.core_rd1, rm[bus.core_ra1]);
            if (e_stall) begin
                cap = rm[bus.host_addr];
                if (e_w) rm[bus.host_addr] = bus.host_wdata;
            end else if (e_w) begin
                rm[bus.core_ra1] = bus.core_wd;
            end
            if (bus.host_req && c >= next_ok) begin
                g       = c + 1;
                next_ok = c + 2 + GAP;
            end
            if (e_ack && $urandom_range(0, 1) == 1) rel = 1'b1;
        end
        cyc();
        idle_inputs();
        settle();
        for (int i = 1; i < 8; i++) chk($sformatf("rnd_final_r%0d", i), rf[i], rm[i]);

`ifdef REGS_CTRL_STATS_EN
        // 256 host accesses wrap both counters back to zero.
        repeat (GAP + 1) cyc();
        reset = 1'b1;
        settle();
        cyc();
        reset         = 1'b0;
        bus.host_req  = 1'b1;
        bus.host_addr = 3'd1;
        settle();
        chk("wrap_start_host_cnt", host_cnt, 8'd0);
        for (int c = 1; c < 256 * (GAP + 2); c++) begin
            cyc();
            settle();
            if (c == 2) begin
                chk("wrap_c2_host_cnt", host_cnt, 8'd1);
                chk("wrap_c2_stall_cnt", stall_cnt, 8'd1);
            end
        end
        cyc();
        bus.host_req = 1'b0;
        settle();
        chk("wrap_host_cnt", host_cnt, 8'd0);
        chk("wrap_stall_cnt", stall_cnt, 8'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regs_port_ctrl.md
Name: regs_port_ctrl

Overview:
- Owns the 8-entry register file's two read ports and its single write port.
- The write address shares the Raddr1 path.
- Multiplexes the core datapath (read every cycle, write on retire) against a host/debug requester that reads and writes registers one at a time.
- Host access steals one core cycle; a cool-down counter then guarantees the core progress between host grants.

Parameters:
N, 8, register data width
AW, 3, register address width (2^AW registers, r0 reads as zero)
HOST_GAP, 4, minimum number of core-owned cycles after each host access (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
core_ra1  in  AW  core read address 1; also core write address when core_we=1
core_ra2  in  AW  core read address 2
core_we  in  1  core write request (retire)
core_wd  in  N  core write data
core_stall  out  1  core must hold its inputs and not retire this cycle
core_rd1  out  N  read data 1 to core (pass-through of rf_rdata1)
core_rd2  out  N  read data 2 to core (pass-through of rf_rdata2)
host_req  in  1  host access request, level; held until host_ack
host_we  in  1  1=write, 0=read; stable while host_req
host_addr  in  AW  host register address; stable while host_req
host_wdata  in  N  host write data; stable while host_req
host_ack  out  1  one-cycle completion pulse, registered
host_rdata  out  N  captured read data, valid with host_ack, held until next ack
rf_write  out  1  register file write enable
rf_wdata  out  N  register file write data
rf_raddr1  out  AW  register file address 1 (read and write)
rf_raddr2  out  AW  register file address 2
rf_rdata1  in  N  register file read data 1 (combinational)
rf_rdata2  in  N  register file read data 2 (combinational)

Behaviour:
- FSM states: IDLE, HOST_ACC, COOLDOWN.
- Reset values: state IDLE, gap counter 0, host_ack 0, host_rdata 0.
- While reset=1, rf_write is forced to 0 and core_stall is 0.
- IDLE:
  - Core owns the ports: rf_raddr1=core_ra1, rf_raddr2=core_ra2, rf_wdata=core_wd, rf_write=core_we.
  - If host_req=1, go to HOST_ACC at the next edge. Core is not stalled in the decision cycle.
- HOST_ACC (exactly 1 cycle):
  - core_stall=1 (combinational from state).
  - rf_raddr1=host_addr, rf_raddr2=core_ra2, rf_wdata=host_wdata, rf_write=host_we.
  - Core write is suppressed.
  - At the edge: host_rdata<=rf_rdata1 (old value on a write, 0 for r0), host_ack<=1, gap counter<=HOST_GAP, go to COOLDOWN.
- COOLDOWN:
  - Port muxing as IDLE; core not stalled; host_req ignored.
  - Counter decrements each cycle.
  - Leave to IDLE on the edge where counter==1, giving exactly HOST_GAP core cycles.
- host_ack is high for exactly the first COOLDOWN cycle.
- host_req still high after the ack cycle counts as a new request; it is serviced after cool-down.
- Host request latency: grant 1 cycle after host_req rises in IDLE; ack 2 cycles after.
- Writes to address 0 are suppressed (rf_write=0) for both core and host; r0 stays zero.
- Core write convention: core_we=1 requires core_ra1 to equal the destination register (two-operand format). The write lands at the edge ending the cycle.
- core_rd1/core_rd2 always pass through rf_rdata1/rf_rdata2. They are meaningless to the core while core_stall=1.
- Reset mid-HOST_ACC: no write that cycle, no ack, state IDLE next cycle. The host must re-request.
- Reset mid-COOLDOWN: counter cleared, IDLE next cycle, pending host_ack pulse dropped.

Optional Feature:
REGS_CTRL_STATS_EN
- Defined:
  - Adds output ports host_cnt (8 bits), a count of completed host accesses, and stall_cnt (8 bits), a count of core_stall cycles.
  - Both cleared by reset, increment by 1, wrap 255->0.
  - host_cnt increments on the edge that raises host_ack; stall_cnt increments every cycle core_stall=1.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then core writes 8'h5A to r3 (core_we=1, core_ra1=3) -> next cycle core_rd1=8'h5A with core_ra1=3; host_ack=0, core_stall=0 throughout.
- Host write 8'hC3 to r5 (host_req=1 cycle 0) -> core_stall=1 in cycle 1 only; host_ack=1 in cycle 2; core read of r5 in cycle 3 returns 8'hC3.
- Host read r3 after test 1 -> host_rdata=8'h5A with host_ack; with core_we=1 during HOST_ACC, r(core_ra1) is unchanged.
- host_req held high continuously, HOST_GAP=4 -> core_stall pulses exactly every 6 cycles (grant, ack, then 4 core cycles); host_ack count matches the stall count.
- Core and host write to r0 (8'hFF) -> rf_write=0 in those cycles; r0 reads 0.
- Assert reset during HOST_ACC of a host write to r2 -> r2 unchanged, no host_ack, state IDLE; with REGS_CTRL_STATS_EN, host_cnt=0 and 256 host accesses wrap host_cnt to 0.
